// File: rtl/xgemac_wb_pkg.sv
// Shared register offsets and responder state encoding for the XGEMAC Wishbone slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xgemac_wb_pkg;

   // Byte offsets of the management registers; all are word aligned
   localparam int ADDR_CONFIG   = 'h00;
   localparam int ADDR_STATUS   = 'h04;
   localparam int ADDR_INT_PEND = 'h08;
   localparam int ADDR_INT_MASK = 'h0C;
   localparam int ADDR_SCRATCH  = 'h10;

   typedef enum logic {IDLE, ACK} wb_resp_state_e;

endpackage

// File: rtl/xgemac_wb_int_ctrl.sv
// Interrupt pending/mask registers with write-1-to-clear and event-over-clear priority.
// Latency: pend/mask update at the write edge; wb_int_o follows one cycle later.
// Backpressure: none, events are accepted every cycle.
module xgemac_wb_int_ctrl #(
   parameter int NUM_INT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_INT-1:0] evt,
   input  logic               wr_pend,
   input  logic               wr_mask,
   input  logic [NUM_INT-1:0] wdata,
   output logic [NUM_INT-1:0] pend,
   output logic [NUM_INT-1:0] mask,
   output logic               wb_int_o
);

   logic [NUM_INT-1:0] clr;

   // A W1C write only clears bits during the cycle the write commits
   always_comb begin
      clr = '0;
      if (wr_pend)
         clr = wdata;
   end

   // Events are OR'd in after the clear so a same-cycle event keeps its bit set
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend     <= '0;
         mask     <= '0;
         wb_int_o <= 1'b0;
      end else begin
         pend     <= (pend & ~clr) | evt;
         if (wr_mask)
            mask <= wdata;
         wb_int_o <= |(pend & mask);
      end
   end

endmodule

// File: rtl/xgemac_wb_reg_responder.sv
// Wishbone classic slave for XGEMAC management registers; XGEMAC_WB_ERR_EN adds wb_err_o for bad addresses.
// Latency: request sampled at edge N, ack (or err) high for exactly cycle N+1; writes commit at edge N.
// Backpressure: none beyond the mandatory idle cycle after each ack (peak 1 transfer per 2 cycles).
module xgemac_wb_reg_responder
   import xgemac_wb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int NUM_INT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   output logic              wb_ack_o,
`ifdef XGEMAC_WB_ERR_EN
   output logic              wb_err_o,
`endif
   output logic [DATA_W-1:0] wb_dat_o,
   output logic              wb_int_o,
   input  logic [NUM_INT-1:0] int_evt_i,
   input  logic [DATA_W-1:0] status_i,
   output logic [DATA_W-1:0] cfg_o
);

   wb_resp_state_e     state;
   logic [DATA_W-1:0]  scratch;
   logic [NUM_INT-1:0] pend;
   logic [NUM_INT-1:0] mask;
   logic [DATA_W-1:0]  rd_dat;
   logic               take;
   logic               sel_cfg, sel_sts, sel_pend, sel_mask, sel_scr;
`ifdef XGEMAC_WB_ERR_EN
   logic               hit;
`endif

   // Offsets are word aligned, so an exact match also rejects misaligned addresses
   assign sel_cfg  = (wb_adr_i == ADDR_W'(ADDR_CONFIG));
   assign sel_sts  = (wb_adr_i == ADDR_W'(ADDR_STATUS));
   assign sel_pend = (wb_adr_i == ADDR_W'(ADDR_INT_PEND));
   assign sel_mask = (wb_adr_i == ADDR_W'(ADDR_INT_MASK));
   assign sel_scr  = (wb_adr_i == ADDR_W'(ADDR_SCRATCH));
`ifdef XGEMAC_WB_ERR_EN
   assign hit      = sel_cfg | sel_sts | sel_pend | sel_mask | sel_scr;
`endif

   // A request is only accepted from IDLE; a strobe held through ACK is ignored
   assign take = (state == IDLE) && wb_cyc_i && wb_stb_i;

   // Read mux of pre-write register values; unmapped addresses read as zero
   always_comb begin
      rd_dat = '0;
      if (sel_cfg)
         rd_dat = cfg_o;
      else if (sel_sts)
         rd_dat = status_i;
      else if (sel_pend)
         rd_dat = DATA_W'(pend);
      else if (sel_mask)
         rd_dat = DATA_W'(mask);
      else if (sel_scr)
         rd_dat = scratch;
   end

   xgemac_wb_int_ctrl #(
      .NUM_INT (NUM_INT)
   ) u_int_ctrl (
      .clk      (clk),
      .rst      (rst),
      .evt      (int_evt_i),
      .wr_pend  (take && wb_we_i && sel_pend),
      .wr_mask  (take && wb_we_i && sel_mask),
      .wdata    (wb_dat_i[NUM_INT-1:0]),
      .pend     (pend),
      .mask     (mask),
      .wb_int_o (wb_int_o)
   );

   // Responder FSM: commits writes and registers the reply on acceptance, clears it in ACK
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         wb_ack_o <= 1'b0;
`ifdef XGEMAC_WB_ERR_EN
         wb_err_o <= 1'b0;
`endif
         wb_dat_o <= '0;
         cfg_o    <= '0;
         scratch  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state    <= ACK;
`ifdef XGEMAC_WB_ERR_EN
                  wb_ack_o <= hit;
                  wb_err_o <= !hit;
`else
                  wb_ack_o <= 1'b1;
`endif
                  wb_dat_o <= wb_we_i ? '0 : rd_dat;
                  if (wb_we_i && sel_cfg)
                     cfg_o <= wb_dat_i;
                  if (wb_we_i && sel_scr)
                     scratch <= wb_dat_i;
               end else begin
                  wb_ack_o <= 1'b0;
`ifdef XGEMAC_WB_ERR_EN
                  wb_err_o <= 1'b0;
`endif
                  wb_dat_o <= '0;
               end
            end
            ACK: begin
               state    <= IDLE;
               wb_ack_o <= 1'b0;
`ifdef XGEMAC_WB_ERR_EN
               wb_err_o <= 1'b0;
`endif
               wb_dat_o <= '0;
            end
            default: begin
               state    <= IDLE;
               wb_ack_o <= 1'b0;
`ifdef XGEMAC_WB_ERR_EN
               wb_err_o <= 1'b0;
`endif
               wb_dat_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xgemac_wb_reg_responder.sv
// Self-checking bench for xgemac_wb_reg_responder: directed scenarios plus random traffic vs a register-map model.
// Latency: model predicts outputs after every rising edge; outputs sampled on the falling edge.
// Backpressure: the model tracks the one-cycle busy window after each accepted request.
`timescale 1ns/1ps
module tb_xgemac_wb_reg_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  wb_adr_i;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [31:0] wb_dat_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        wb_int_o;
   logic [7:0]  int_evt_i;
   logic [31:0] status_i;
   logic [31:0] cfg_o;
   logic        err_s;
`ifdef XGEMAC_WB_ERR_EN
   logic        wb_err_o;
   localparam bit ERR_EN = 1'b1;
   assign err_s = wb_err_o;
`else
   localparam bit ERR_EN = 1'b0;
   assign err_s = 1'b0;
`endif

   always #5 clk = ~clk;

   xgemac_wb_reg_responder dut (
      .clk       (clk),
      .rst       (rst),
      .wb_adr_i  (wb_adr_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_we_i   (wb_we_i),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_o  (wb_ack_o),
`ifdef XGEMAC_WB_ERR_EN
      .wb_err_o  (wb_err_o),
`endif
      .wb_dat_o  (wb_dat_o),
      .wb_int_o  (wb_int_o),
      .int_evt_i (int_evt_i),
      .status_i  (status_i),
      .cfg_o     (cfg_o)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Reference model: register map contents plus the expected reply/irq after each edge
   logic [31:0] m_cfg, m_scr;
   logic [7:0]  m_pend, m_mask;
   bit          m_busy;
   logic        e_ack, e_err, e_int;
   logic [31:0] e_dat;

   function automatic bit mapped(input logic [7:0] a);
      return (a[1:0] == 2'b00) && (a < 8'h14);
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      if (!mapped(a))
         return 32'h0;
      case (a >> 2)
         0: return m_cfg;
         1: return status_i;
         2: return {24'h0, m_pend};
         3: return {24'h0, m_mask};
         default: return m_scr;
      endcase
   endfunction

   task automatic cycle();
      bit          take;
      logic [7:0]  clr;
      @(posedge clk);
      if (!rst) begin
         m_cfg = '0; m_scr = '0; m_pend = '0; m_mask = '0; m_busy = 0;
         e_ack = 0; e_err = 0; e_int = 0; e_dat = '0;
      end else begin
         take  = !m_busy && wb_cyc_i && wb_stb_i;
         e_int = |(m_pend & m_mask);
         e_ack = take && (!ERR_EN || mapped(wb_adr_i));
         e_err = take && ERR_EN && !mapped(wb_adr_i);
         e_dat = (take && !wb_we_i) ? model_read(wb_adr_i) : 32'h0;
         clr   = '0;
         if (take && wb_we_i && mapped(wb_adr_i)) begin
            case (wb_adr_i >> 2)
               0: m_cfg  = wb_dat_i;
               2: clr    = wb_dat_i[7:0];
               3: m_mask = wb_dat_i[7:0];
               4: m_scr  = wb_dat_i;
               default: ;
            endcase
         end
         m_pend = (m_pend & ~clr) | int_evt_i;
         m_busy = take;
      end
      @(negedge clk);
      check("ack", {31'h0, wb_ack_o}, {31'h0, e_ack});
      check("dat", wb_dat_o, e_dat);
      check("int", {31'h0, wb_int_o}, {31'h0, e_int});
      check("cfg", cfg_o, m_cfg);
`ifdef XGEMAC_WB_ERR_EN
      check("err", {31'h0, err_s}, {31'h0, e_err});
`endif
   endtask

   // One bus access: request cycle followed by a cycle with the strobe dropped
   task automatic xfer(input bit we, input logic [7:0] a, input logic [31:0] d, input logic [7:0] evt,
                       output logic ack, output logic err, output logic [31:0] rd);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d; int_evt_i = evt;
      cycle();
      ack = wb_ack_o; err = err_s; rd = wb_dat_o;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; int_evt_i = 0;
      cycle();
   endtask

   logic        ack, err;
   logic [31:0] rd, d_last;
   int          n_ack, n_dbl;
   bit          prev_ack;
   logic [7:0]  adrs [9];

   initial begin
      adrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h24, 8'h02, 8'h0E};
      rst = 0; wb_adr_i = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_dat_i = 0;
      int_evt_i = 0; status_i = 32'hA5A5_0001;

      // Reset for 3 cycles, then read CONFIG
      repeat (3) cycle();
      check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      check("rst_int", {31'h0, wb_int_o}, 32'h0);
      rst = 1;
      xfer(0, 8'h00, 0, 0, ack, err, rd);
      check("rst_rd_ack", {31'h0, ack}, 32'h1);
      check("rst_rd_cfg", rd, 32'h0);

      // CONFIG write then read
      xfer(1, 8'h00, 32'hDEAD_BEEF, 0, ack, err, rd);
      check("cfg_wr_ack", {31'h0, ack}, 32'h1);
      check("cfg_o", cfg_o, 32'hDEAD_BEEF);
      xfer(0, 8'h00, 0, 0, ack, err, rd);
      check("cfg_rd", rd, 32'hDEAD_BEEF);

      // Interrupts: mask 0x04, event pulse 0x05
      xfer(1, 8'h0C, 32'h04, 0, ack, err, rd);
      int_evt_i = 8'h05;
      cycle();
      int_evt_i = 0;
      check("int_lag", {31'h0, wb_int_o}, 32'h0);
      cycle();
      check("int_set", {31'h0, wb_int_o}, 32'h1);
      xfer(0, 8'h08, 0, 0, ack, err, rd);
      check("pend_rd", rd, 32'h05);
      xfer(1, 8'h08, 32'h04, 0, ack, err, rd);
      check("int_clr", {31'h0, wb_int_o}, 32'h0);
      xfer(0, 8'h08, 0, 0, ack, err, rd);
      check("pend_w1c", rd, 32'h01);

      // Same-cycle event and W1C on bit 0: event wins
      xfer(1, 8'h08, 32'h01, 8'h01, ack, err, rd);
      xfer(0, 8'h08, 0, 0, ack, err, rd);
      check("pend_prio", rd, 32'h01);

      // Strobe held 6 cycles writing SCRATCH: 3 single-cycle acks
      n_ack = 0; n_dbl = 0; prev_ack = 0; d_last = 0;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 8'h10;
      for (int i = 0; i < 6; i++) begin
         wb_dat_i = $urandom;
         if (i == 4) d_last = wb_dat_i;
         cycle();
         if (wb_ack_o) n_ack++;
         if (wb_ack_o && prev_ack) n_dbl++;
         prev_ack = wb_ack_o;
      end
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      cycle();
      check("burst_acks", n_ack, 3);
      check("burst_wide", n_dbl, 0);
      xfer(0, 8'h10, 0, 0, ack, err, rd);
      check("scr_rd", rd, d_last);

      // Reset asserted during ACK drops the transfer
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 8'h00;
      cycle();
      rst = 0;
      cycle();
      check("rst_ack_drop", {31'h0, wb_ack_o}, 32'h0);
      cycle();
      check("rst_ack_hold", {31'h0, wb_ack_o}, 32'h0);
      check("rst_cfg_clr", cfg_o, 32'h0);
      rst = 1; wb_cyc_i = 0; wb_stb_i = 0;
      cycle();

      // Unmapped and misaligned reads; write to STATUS ignored
      xfer(0, 8'h24, 0, 0, ack, err, rd);
      check("unm_ack", {31'h0, ack}, ERR_EN ? 32'h0 : 32'h1);
      check("unm_err", {31'h0, err}, ERR_EN ? 32'h1 : 32'h0);
      check("unm_dat", rd, 32'h0);
      xfer(0, 8'h02, 0, 0, ack, err, rd);
      check("mis_ack", {31'h0, ack}, ERR_EN ? 32'h0 : 32'h1);
      status_i = 32'h1234_5678;
      xfer(1, 8'h04, 32'hFFFF_FFFF, 0, ack, err, rd);
      xfer(0, 8'h04, 0, 0, ack, err, rd);
      check("sts_ro", rd, 32'h1234_5678);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         rst       = ($urandom_range(0, 59) != 0);
         wb_cyc_i  = ($urandom_range(0, 3) != 0);
         wb_stb_i  = ($urandom_range(0, 3) != 0);
         wb_we_i   = $urandom_range(0, 1);
         wb_adr_i  = adrs[$urandom_range(0, 8)];
         wb_dat_i  = $urandom;
         int_evt_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         status_i  = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
